mp_addsub_serial: RTL and testbench

//   Limb-serial multi-precision adder/subtractor. Responder side of the start/done handshake driven by the

---
 rtl/mp_addsub_serial_if.sv | 22 ++
 rtl/mp_addsub_serial.sv | 131 +++++++++++++
 tb/tb_mp_addsub_serial.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/mp_addsub_serial_if.sv
// Start/done request bus between a requester and the limb-serial adder/subtractor.
// MPADD_ZERO_FLAG_EN adds the registered zero-result flag.
interface mp_addsub_serial_if #(
    parameter int unsigned WIDTH = 514
);
    logic             start;
    logic             subtract;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH:0]   C;
    logic             done;
    logic             busy;
`ifdef MPADD_ZERO_FLAG_EN
    logic             zero;

    modport master (output start, subtract, A, B, input C, done, busy, zero);
    modport slave  (input start, subtract, A, B, output C, done, busy, zero);
`else
    modport master (output start, subtract, A, B, input C, done, busy);
    modport slave  (input start, subtract, A, B, output C, done, busy);
`endif
endinterface

// File: rtl/mp_addsub_serial.sv
// Limb-serial multi-precision adder/subtractor, one LIMB-bit slice per cycle.
// Optional zero-result flag when MPADD_ZERO_FLAG_EN is defined.
module mp_addsub_serial #(
    parameter int unsigned WIDTH = 514,
    parameter int unsigned LIMB  = 64
) (
    input  logic               clk,
    input  logic               rst,
    mp_addsub_serial_if.slave  bus
);
    localparam int unsigned NLIMB = (WIDTH + LIMB) / LIMB;
    localparam int unsigned P     = NLIMB * LIMB;
    localparam int unsigned CW    = (NLIMB > 1) ? $clog2(NLIMB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NLIMB - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  ctr_q, ctr_d;
    logic           carry_q, carry_d;
    logic [P-1:0]   opa_q, opa_d;
    logic [P-1:0]   opb_q, opb_d;
    logic [WIDTH:0] c_q, c_d;
    logic           done_q, done_d;
    logic           busy_q, busy_d;
    logic [LIMB:0]  sum;

    // opa doubles as the result accumulator: consumed limbs shift out the bottom,
    // produced limbs shift in at the top, so after NLIMB steps it holds the result.
    always_comb sum = {1'b0, opa_q[LIMB-1:0]} + {1'b0, opb_q[LIMB-1:0]} + (LIMB+1)'(carry_q);

`ifdef MPADD_ZERO_FLAG_EN
    localparam logic [LIMB-1:0] TOP_MASK = {LIMB{1'b1}} >> (P - WIDTH - 1);
    logic nz_q, nz_d, zero_q, zero_d, limb_nz;

    // Only result bits that land in C count toward the flag.
    always_comb limb_nz = (ctr_q == LAST) ? |(sum[LIMB-1:0] & TOP_MASK) : |sum[LIMB-1:0];
`endif

    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        carry_d = carry_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        c_d     = c_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
`ifdef MPADD_ZERO_FLAG_EN
        nz_d    = nz_q;
        zero_d  = zero_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    opa_d   = P'(bus.A);
                    opb_d   = bus.subtract ? ~P'(bus.B) : P'(bus.B);
                    carry_d = bus.subtract;
                    ctr_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
`ifdef MPADD_ZERO_FLAG_EN
                    nz_d    = 1'b0;
`endif
                end else begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                opa_d   = (opa_q >> LIMB) | (P'(sum[LIMB-1:0]) << (P - LIMB));
                opb_d   = opb_q >> LIMB;
                carry_d = sum[LIMB];
                ctr_d   = ctr_q + CW'(1);
`ifdef MPADD_ZERO_FLAG_EN
                nz_d    = nz_q | limb_nz;
`endif
                if (ctr_q == LAST) begin
                    c_d     = opa_d[WIDTH:0];
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_DONE;
`ifdef MPADD_ZERO_FLAG_EN
                    zero_d  = ~(nz_q | limb_nz);
`endif
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ctr_q   <= '0;
            carry_q <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            c_q     <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef MPADD_ZERO_FLAG_EN
            nz_q    <= 1'b0;
            zero_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            carry_q <= carry_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            c_q     <= c_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
`ifdef MPADD_ZERO_FLAG_EN
            nz_q    <= nz_d;
            zero_q  <= zero_d;
`endif
        end
    end

    assign bus.C    = c_q;
    assign bus.done = done_q;
    assign bus.busy = busy_q;
`ifdef MPADD_ZERO_FLAG_EN
    assign bus.zero = zero_q;
`endif
endmodule

// File: tb/tb_mp_addsub_serial.sv
// Scoreboard bench for mp_addsub_serial: driver pushes expected results, monitor checks them at done.
// Honours MPADD_ZERO_FLAG_EN for the zero flag.
module tb_mp_addsub_serial;
    localparam int unsigned W = 514;

    typedef struct {
        logic [W:0] c;
        logic       z;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    logic prev_done = 1'b0;
    exp_t sb[$];

    mp_addsub_serial_if #(.WIDTH(W)) bus ();

    mp_addsub_serial #(.WIDTH(W), .LIMB(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            chk("done_width", W'(prev_done), '0);
            if (sb.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result_C", bus.C, e.c);
                chk("done_cycle", (W+1)'(cyc), (W+1)'(e.cyc));
`ifdef MPADD_ZERO_FLAG_EN
                chk("zero_flag", (W+1)'(bus.zero), (W+1)'(e.z));
`endif
            end
        end
        prev_done = bus.done;
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         input logic [W:0] exp_c, input logic exp_z);
        exp_t e;
        @(negedge clk);
        bus.A = a; bus.B = b; bus.subtract = sub; bus.start = 1'b1;
        e.c = exp_c; e.z = exp_z; e.cyc = cyc + 10;
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", (W+1)'(sb.size()), '0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        logic [W:0] e;
        bus.start = 1'b1; bus.subtract = 1'b0; bus.A = '0; bus.B = '0;

        // 1: reset held with start high
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_C", bus.C, '0);
            chk("rst_done", (W+1)'(bus.done), '0);
            chk("rst_busy", (W+1)'(bus.busy), '0);
        end
        bus.start = 1'b0;
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("post_rst_busy", (W+1)'(bus.busy), '0);
        end

        // 2: carry ripples through every limb, with busy profile
        e = '0; e[W] = 1'b1;
        issue({W{1'b1}}, W'(1), 1'b0, e, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk("busy_run", (W+1)'(bus.busy), (W+1)'(1));
            @(negedge clk);
        end
        chk("busy_run", (W+1)'(bus.busy), (W+1)'(1));
        @(negedge clk);
        chk("busy_done", (W+1)'(bus.busy), '0);
        drain();

        // 3: borrow and no-borrow subtract
        e = '1; e[0] = 1'b0;
        issue(W'(5), W'(7), 1'b1, e, 1'b0);
        drain();
        issue(W'(7), W'(5), 1'b1, (W+1)'(2), 1'b0);
        drain();

        // 4: borrow chain across the limb-0/limb-1 boundary
        issue(W'(1) << 64, W'(1) << 64, 1'b1, '0, 1'b1);
        drain();
        issue(W'(1) << 64, W'(1), 1'b1, (W+1)'({64{1'b1}}), 1'b0);
        drain();

        // 5: start held high, operands valid only at accepting edges
        for (int j = 0; j < 4; j++) begin
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                bus.start = 1'b1;
                if (c == 0) begin
                    exp_t x;
                    x.cyc = cyc + 10;
                    case (j)
                        0: begin bus.A = W'(100);  bus.B = W'(200); bus.subtract = 1'b0;
                                 x.c = (W+1)'(300); x.z = 1'b0; end
                        1: begin bus.A = W'(1000); bus.B = W'(1);   bus.subtract = 1'b1;
                                 x.c = (W+1)'(999); x.z = 1'b0; end
                        2: begin bus.A = W'(3);    bus.B = W'(3);   bus.subtract = 1'b1;
                                 x.c = '0; x.z = 1'b1; end
                        default: begin
                                 bus.A = W'(1) << 513; bus.B = W'(1) << 513; bus.subtract = 1'b0;
                                 x.c = (W+1)'(1) << 514; x.z = 1'b0; end
                    endcase
                    sb.push_back(x);
                end else begin
                    bus.A = W'({$urandom(), $urandom()});
                    bus.B = W'({$urandom(), $urandom()});
                    bus.subtract = 1'($urandom_range(0, 1));
                end
            end
        end
        @(negedge clk);
        bus.start = 1'b0;
        drain();

        // 6: asynchronous reset with ctr at 4 aborts the operation
        @(negedge clk);
        bus.A = W'(12345); bus.B = W'(6789); bus.subtract = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_C", bus.C, '0);
        chk("async_rst_busy", (W+1)'(bus.busy), '0);
        chk("async_rst_done", (W+1)'(bus.done), '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("abort_C", bus.C, '0);
        issue(W'(1), W'(1), 1'b0, (W+1)'(2), 1'b0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end
endmodule
